instruction_sequencer: RTL and testbench

//   Program store plus fetch sequencer directly upstream of the executor.

---
 rtl/instruction_sequencer.sv | 115 +++++++++++
 tb/tb_instruction_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Program store plus fetch sequencer feeding the executor one opcode per Done handshake.
// Optional single-step mode (PAUSE state, Step input) is enabled by defining SINGLE_STEP_EN.
module instruction_sequencer #(
    parameter int                 OP_LEN  = 20,
    parameter int                 PC_W    = 4,
    parameter logic [OP_LEN-1:0]  HALT_OP = 20'hFFFFF
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              LoadEn,
    input  logic [PC_W-1:0]   LoadAddr,
    input  logic [OP_LEN-1:0] LoadData,
    input  logic              Start,
    input  logic              Done,
`ifdef SINGLE_STEP_EN
    input  logic              Step,
`endif
    output logic [OP_LEN-1:0] OpCode,
    output logic              OpValid,
    output logic [PC_W-1:0]   Pc,
    output logic              Busy,
    output logic              Halted
);

    localparam int DEPTH = 2 ** PC_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_HALTED = 3'd3,
        S_PAUSE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [OP_LEN-1:0]   store_q [DEPTH];
    logic [OP_LEN-1:0]   opcode_q;
    logic                opvalid_q;
    logic [PC_W-1:0]     pc_q;
    logic                busy_q;
    logic                halted_q;
    logic [OP_LEN-1:0]   word_d;

    assign word_d = store_q[pc_q];

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            opvalid_q <= 1'b0;
            pc_q      <= '0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= HALT_OP;
            end
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    // A load in the same cycle as Start takes priority; Start is dropped.
                    if (LoadEn) begin
                        store_q[LoadAddr] <= LoadData;
                    end else if (Start) begin
                        pc_q     <= '0;
                        state_q  <= S_FETCH;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (word_d == HALT_OP) begin
                        state_q  <= S_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        opcode_q  <= word_d;
                        opvalid_q <= 1'b1;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (Done) begin
                        opvalid_q <= 1'b0;
                        pc_q      <= pc_q + PC_W'(1);
`ifdef SINGLE_STEP_EN
                        state_q   <= S_PAUSE;
`else
                        state_q   <= S_FETCH;
`endif
                    end
                end
`ifdef SINGLE_STEP_EN
                S_PAUSE: begin
                    if (Step) begin
                        state_q <= S_FETCH;
                    end
                end
`endif
                default: begin
                    state_q   <= S_IDLE;
                    opvalid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign OpCode  = opcode_q;
    assign OpValid = opvalid_q;
    assign Pc      = pc_q;
    assign Busy    = busy_q;
    assign Halted  = halted_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized self-checking bench for instruction_sequencer against a program-walk reference model.
// Define SINGLE_STEP_EN for both files to exercise the PAUSE/Step path.
module tb_instruction_sequencer;

    localparam int          OP_LEN = 20;
    localparam int          PC_W   = 4;
    localparam int          DEPTH  = 16;
    localparam logic [19:0] HALT   = 20'hFFFFF;

    logic              Clock;
    logic              ResetN;
    logic              LoadEn;
    logic [PC_W-1:0]   LoadAddr;
    logic [OP_LEN-1:0] LoadData;
    logic              Start;
    logic              Done;
`ifdef SINGLE_STEP_EN
    logic              Step;
`endif
    logic [OP_LEN-1:0] OpCode;
    logic              OpValid;
    logic [PC_W-1:0]   Pc;
    logic              Busy;
    logic              Halted;

    int n_checks;
    int n_errors;
    logic [19:0] model_mem [DEPTH];

    instruction_sequencer dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadData (LoadData),
        .Start    (Start),
        .Done     (Done),
`ifdef SINGLE_STEP_EN
        .Step     (Step),
`endif
        .OpCode   (OpCode),
        .OpValid  (OpValid),
        .Pc       (Pc),
        .Busy     (Busy),
        .Halted   (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = HALT;
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        LoadEn = 1'b0;
        Start  = 1'b0;
        Done   = 1'b0;
`ifdef SINGLE_STEP_EN
        Step   = 1'b0;
`endif
        tick();
        ResetN = 1'b1;
        model_clear();
    endtask

    task automatic load(input int addr, input logic [19:0] data);
        LoadEn   = 1'b1;
        LoadAddr = PC_W'(addr);
        LoadData = data;
        tick();
        LoadEn   = 1'b0;
        model_mem[addr] = data;
    endtask

    function automatic logic [19:0] rand_op();
        logic [19:0] d;
        d = 20'($urandom);
        if (d == HALT) d = 20'h0;
        return d;
    endfunction

    // Walks the model program from address 0; leaves the DUT in WAIT if max_ops is reached first.
    task automatic run(input int max_ops, input int stall_at, output bit halted_out);
        int pc;
        int hold;
        pc = 0;
        halted_out = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val("busy_after_start", Busy, 1);
        tick();
        for (int n = 0; n < max_ops; n++) begin
            if (model_mem[pc] == HALT) begin
                check_val("halted", Halted, 1);
                check_val("halt_opvalid", OpValid, 0);
                check_val("halt_busy", Busy, 0);
                check_val("halt_pc", Pc, pc);
                halted_out = 1'b1;
                return;
            end
            check_val("opvalid", OpValid, 1);
            check_val("opcode", OpCode, model_mem[pc]);
            check_val("pc", Pc, pc);
            check_val("busy_run", Busy, 1);
            check_val("not_halted", Halted, 0);
            if (n + 1 >= max_ops) return;
            if (n == stall_at) begin
                LoadEn   = 1'b1;
                LoadAddr = PC_W'(pc + 1);
                LoadData = HALT;
                Start    = 1'b1;
                hold     = 10;
            end else begin
                hold = $urandom_range(0, 3);
            end
            for (int h = 0; h < hold; h++) begin
                tick();
                check_val("hold_opvalid", OpValid, 1);
                check_val("hold_opcode", OpCode, model_mem[pc]);
            end
            LoadEn = 1'b0;
            Start  = 1'b0;
            Done   = 1'b1;
            tick();
            Done = 1'b0;
            pc = (pc + 1) % DEPTH;
            check_val("done_opvalid", OpValid, 0);
            check_val("done_pc", Pc, pc);
`ifdef SINGLE_STEP_EN
            for (int s = 0; s < 2; s++) begin
                tick();
                check_val("pause_busy", Busy, 1);
                check_val("pause_opvalid", OpValid, 0);
            end
            Step = 1'b1;
            tick();
            Step = 1'b0;
`endif
            tick();
        end
    endtask

    initial begin
        bit h;
        n_checks = 0;
        n_errors = 0;
        LoadAddr = '0;
        LoadData = '0;
        do_reset();
        ResetN = 1'b0;
        tick();
        check_val("rst_opcode", OpCode, 0);
        check_val("rst_opvalid", OpValid, 0);
        check_val("rst_pc", Pc, 0);
        check_val("rst_busy", Busy, 0);
        check_val("rst_halted", Halted, 0);
        ResetN = 1'b1;

        // Empty program halts immediately at address 0.
        run(4, -1, h);
        check_val("empty_halts", h, 1);

        Done = 1'b1;
        tick();
        Done = 1'b0;
        check_val("done_idle_halted", Halted, 1);
        check_val("done_idle_busy", Busy, 0);

        LoadEn = 1'b1; Start = 1'b1; LoadAddr = 4'd0; LoadData = 20'h00001;
        tick();
        LoadEn = 1'b0; Start = 1'b0;
        model_mem[0] = 20'h00001;
        check_val("load_beats_start", Busy, 0);

        load(1, 20'h00002);
        load(2, HALT);
        run(10, -1, h);
        check_val("prog2_halts", h, 1);

        // Stall in WAIT while Start/LoadEn are asserted; the model store is left untouched.
        for (int i = 0; i < 6; i++) load(i, rand_op());
        load(6, HALT);
        run(20, 0, h);
        check_val("stall_halts", h, 1);

        for (int i = 0; i < DEPTH; i++) load(i, 20'h00010);
        run(20, -1, h);
        check_val("wrap_no_halt", h, 0);

        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        model_clear();
        check_val("midrst_opvalid", OpValid, 0);
        check_val("midrst_pc", Pc, 0);
        check_val("midrst_busy", Busy, 0);
        check_val("midrst_halted", Halted, 0);
        for (int i = 0; i < DEPTH - 1; i++) load(i, rand_op());
        run(20, -1, h);
        check_val("word15_reset_halt", h, 1);

        for (int it = 0; it < 8; it++) begin
            int nl;
            nl = $urandom_range(1, 10);
            for (int k = 0; k < nl; k++) begin
                load($urandom_range(0, DEPTH - 1), ($urandom_range(0, 3) == 0) ? HALT : rand_op());
            end
            run(24, -1, h);
            if (!h) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
